// File: rtl/fp_addsub_seq_if.sv
// Issue handshake and shared 24-bit mantissa adder bus for the FP add/sub sequencer.
interface fp_addsub_seq_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        invalid;
    logic [23:0] add_reg1;
    logic [23:0] add_reg2;
    logic        add_op;
    logic [23:0] add_result;
    logic        add_cout;

    modport slave (
        input  start, a, b, sub, add_result, add_cout,
        output busy, done, result, overflow, invalid, add_reg1, add_reg2, add_op
    );

    modport master (
        output start, a, b, sub, add_result, add_cout,
        input  busy, done, result, overflow, invalid, add_reg1, add_reg2, add_op
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer driving an external
// 24-bit mantissa adder: unpack, align (1 bit/cycle), add, normalise (1 bit/cycle), pack.
module fp_addsub_seq #(
    parameter int ADD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    fp_addsub_seq_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    localparam logic [1:0] LAST_ADD = 2'(ADD_LAT);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic        sub_q, sub_d, sign_q, sign_d, eff_sub_q, eff_sub_d, carry_q, carry_d;
    logic        done_q, done_d, ovf_q, ovf_d, inv_q, inv_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] mant_l_q, mant_l_d, mant_s_q, mant_s_d, mant_r_q, mant_r_d;
    logic [4:0]  shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [7:0]  ea, eb, exp_diff;
    logic [23:0] ma, mb;
    logic        sb_eff, a_ge_b;

    // Unpack view of the latched operands; exponent 0 flushes to zero.
    always_comb begin
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        ma       = (ea != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
        mb       = (eb != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
        sb_eff   = b_q[31] ^ sub_q;
        a_ge_b   = {ea, ma} >= {eb, mb};
        exp_diff = a_ge_b ? (ea - eb) : (eb - ea);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        mant_l_d  = mant_l_q;
        mant_s_d  = mant_s_q;
        mant_r_d  = mant_r_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        inv_d     = inv_q;
        res_d     = res_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    ovf_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                cnt_d     = 2'd0;
                carry_d   = 1'b0;
                eff_sub_d = a_q[31] ^ sb_eff;
                if (ea == 8'hFF || eb == 8'hFF) begin
                    inv_d    = 1'b1;
                    sign_d   = 1'b0;
                    exp_d    = 8'hFF;
                    mant_r_d = 24'h400000;
                    state_d  = S_DONE;
                end else if (ea == 8'd0) begin
                    sign_d   = sb_eff;
                    exp_d    = eb;
                    mant_r_d = {1'b0, b_q[22:0]};
                    state_d  = S_DONE;
                end else if (eb == 8'd0) begin
                    sign_d   = a_q[31];
                    exp_d    = ea;
                    mant_r_d = {1'b0, a_q[22:0]};
                    state_d  = S_DONE;
                end else begin
                    sign_d   = a_ge_b ? a_q[31] : sb_eff;
                    exp_d    = a_ge_b ? ea : eb;
                    mant_l_d = a_ge_b ? ma : mb;
                    mant_s_d = a_ge_b ? mb : ma;
                    // 24 shifts already clear a 24-bit mantissa, so longer distances stop there.
                    shift_d  = (exp_diff >= 8'd24) ? 5'd24 : exp_diff[4:0];
                    state_d  = (exp_diff == 8'd0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                mant_s_d = mant_s_q >> 1;
                shift_d  = shift_q - 5'd1;
                if (shift_q == 5'd1) state_d = S_ADD;
            end
            S_ADD: begin
                if (cnt_q == LAST_ADD) begin
                    mant_r_d = bus.add_result;
                    carry_d  = bus.add_cout & ~eff_sub_q;
                    state_d  = S_NORM;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_NORM: begin
                if (carry_q) begin
                    carry_d = 1'b0;
                    state_d = S_DONE;
                    if (exp_q == 8'd254) begin
                        ovf_d    = 1'b1;
                        exp_d    = 8'hFF;
                        mant_r_d = 24'd0;
                    end else begin
                        exp_d    = exp_q + 8'd1;
                        mant_r_d = {1'b1, mant_r_q[23:1]};
                    end
                end else if (mant_r_q == 24'd0) begin
                    sign_d  = 1'b0;
                    exp_d   = 8'd0;
                    state_d = S_DONE;
                end else if (mant_r_q[23]) begin
                    state_d = S_DONE;
                end else if (exp_q == 8'd1) begin
                    // Next shift would underflow into the denormal range: flush, keep sign.
                    exp_d    = 8'd0;
                    mant_r_d = 24'd0;
                    state_d  = S_DONE;
                end else begin
                    mant_r_d = {mant_r_q[22:0], 1'b0};
                    exp_d    = exp_q - 8'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                res_d   = {sign_q, exp_q, mant_r_q[22:0]};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
            res_q   <= 32'd0;
            cnt_q   <= 2'd0;
            shift_q <= 5'd0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q       <= a_d;
        b_q       <= b_d;
        sub_q     <= sub_d;
        sign_q    <= sign_d;
        eff_sub_q <= eff_sub_d;
        exp_q     <= exp_d;
        mant_l_q  <= mant_l_d;
        mant_s_q  <= mant_s_d;
        mant_r_q  <= mant_r_d;
        carry_q   <= carry_d;
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;
    assign bus.add_reg1 = (state_q == S_ADD) ? mant_l_q : 24'd0;
    assign bus.add_reg2 = (state_q == S_ADD) ? mant_s_q : 24'd0;
    assign bus.add_op   = (state_q == S_ADD) ? eff_sub_q : 1'b0;
endmodule
